// File: rtl/initialization_sequence_controller.sv
// 8259A initialization/operation command-word sequencer: decodes CPU writes into ICW1..ICW4 / OCW1..OCW3
// strobes and keeps the sequencing-relevant configuration fields.
module initialization_sequence_controller #(
    parameter bit LOCK_OCW_UNTIL_INIT = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       write_enable,
    input  logic       address_0,
    input  logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic [2:0] initialization_state,
    output logic       initialization_complete,
    output logic       single_or_cascade_config,
    output logic       set_icw4_config,
    output logic [4:0] interrupt_vector_base,
    output logic [7:0] cascade_config,
    output logic [4:0] icw4_config
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    // Strobe vector bit order: ICW1..ICW4 in [3:0], OCW1..OCW3 in [6:4].
    state_t     state_q, state_d;
    logic [6:0] strobe_q, strobe_d;
    logic       we_q;
    logic       sngl_q, sngl_d;
    logic       ic4_q, ic4_d;
    logic [4:0] vec_q, vec_d;
    logic [7:0] cas_q, cas_d;
    logic [4:0] icw4_q, icw4_d;
    logic       accept;
    logic       ocw_allowed;

    assign accept = write_enable & ~we_q;

    always_comb begin
        state_d     = state_q;
        strobe_d    = '0;
        sngl_d      = sngl_q;
        ic4_d       = ic4_q;
        vec_d       = vec_q;
        cas_d       = cas_q;
        icw4_d      = icw4_q;
        ocw_allowed = 1'b0;

        case (state_q)
            IDLE:      ocw_allowed = ~LOCK_OCW_UNTIL_INIT;
            READY:     ocw_allowed = 1'b1;
            WAIT_ICW2,
            WAIT_ICW3,
            WAIT_ICW4: ocw_allowed = 1'b0;
            default:   state_d = IDLE;
        endcase

        if (accept) begin
            if (!address_0 && internal_data_bus[4]) begin
                strobe_d[0] = 1'b1;
                sngl_d      = internal_data_bus[1];
                ic4_d       = internal_data_bus[0];
                icw4_d      = '0;
                state_d     = WAIT_ICW2;
            end else if (ocw_allowed) begin
                if (address_0)                  strobe_d[4] = 1'b1;
                else if (!internal_data_bus[3]) strobe_d[5] = 1'b1;
                else                            strobe_d[6] = 1'b1;
            end else if (address_0) begin
                case (state_q)
                    WAIT_ICW2: begin
                        strobe_d[1] = 1'b1;
                        vec_d       = internal_data_bus[7:3];
                        if (!sngl_q)    state_d = WAIT_ICW3;
                        else if (ic4_q) state_d = WAIT_ICW4;
                        else            state_d = READY;
                    end
                    WAIT_ICW3: begin
                        strobe_d[2] = 1'b1;
                        cas_d       = internal_data_bus;
                        state_d     = ic4_q ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: begin
                        strobe_d[3] = 1'b1;
                        icw4_d      = internal_data_bus[4:0];
                        state_d     = READY;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            strobe_q <= '0;
            we_q     <= 1'b0;
            sngl_q   <= 1'b0;
            ic4_q    <= 1'b0;
            vec_q    <= '0;
            cas_q    <= '0;
            icw4_q   <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            we_q     <= write_enable;
            sngl_q   <= sngl_d;
            ic4_q    <= ic4_d;
            vec_q    <= vec_d;
            cas_q    <= cas_d;
            icw4_q   <= icw4_d;
        end
    end

    assign write_initial_command_word_1   = strobe_q[0];
    assign write_initial_command_word_2   = strobe_q[1];
    assign write_initial_command_word_3   = strobe_q[2];
    assign write_initial_command_word_4   = strobe_q[3];
    assign write_operation_control_word_1 = strobe_q[4];
    assign write_operation_control_word_2 = strobe_q[5];
    assign write_operation_control_word_3 = strobe_q[6];
    assign initialization_state           = state_q;
    assign initialization_complete        = (state_q == READY);
    assign single_or_cascade_config       = sngl_q;
    assign set_icw4_config                = ic4_q;
    assign interrupt_vector_base          = vec_q;
    assign cascade_config                 = cas_q;
    assign icw4_config                    = icw4_q;

endmodule

// File: tb/tb_initialization_sequence_controller.sv
// Scoreboard bench for initialization_sequence_controller: a reference model queues the expected strobe,
// state and configuration for every write; a negedge monitor pops and compares when a strobe appears.
module tb_initialization_sequence_controller;

    logic       clock;
    logic       reset_n;
    logic       write_enable;
    logic       address_0;
    logic [7:0] internal_data_bus;
    logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic [2:0] initialization_state;
    logic       initialization_complete;
    logic       single_or_cascade_config;
    logic       set_icw4_config;
    logic [4:0] interrupt_vector_base;
    logic [7:0] cascade_config;
    logic [4:0] icw4_config;

    initialization_sequence_controller #(.LOCK_OCW_UNTIL_INIT(1'b1)) dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .write_enable                   (write_enable),
        .address_0                      (address_0),
        .internal_data_bus              (internal_data_bus),
        .write_initial_command_word_1   (icw1),
        .write_initial_command_word_2   (icw2),
        .write_initial_command_word_3   (icw3),
        .write_initial_command_word_4   (icw4),
        .write_operation_control_word_1 (ocw1),
        .write_operation_control_word_2 (ocw2),
        .write_operation_control_word_3 (ocw3),
        .initialization_state           (initialization_state),
        .initialization_complete        (initialization_complete),
        .single_or_cascade_config       (single_or_cascade_config),
        .set_icw4_config                (set_icw4_config),
        .interrupt_vector_base          (interrupt_vector_base),
        .cascade_config                 (cascade_config),
        .icw4_config                    (icw4_config)
    );

    typedef struct {
        int         cyc;
        logic [6:0] stb;
        logic [2:0] st;
        logic [20:0] cfg;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [2:0] m_state;
    logic       m_sngl, m_ic4;
    logic [4:0] m_vec;
    logic [7:0] m_cas;
    logic [4:0] m_icw4;

    wire [6:0]  stb = {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};
    wire [20:0] cfg = {single_or_cascade_config, set_icw4_config, interrupt_vector_base,
                       cascade_config, icw4_config};

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_state = 3'd0; m_sngl = 1'b0; m_ic4 = 1'b0;
        m_vec = '0; m_cas = '0; m_icw4 = '0;
    endtask

    // Reference behaviour of one accepted write; returns the expected strobe vector.
    task automatic model_step(input bit a0, input logic [7:0] d, output logic [6:0] s);
        s = '0;
        if (!a0 && d[4]) begin
            s[0] = 1'b1; m_sngl = d[1]; m_ic4 = d[0]; m_icw4 = '0; m_state = 3'd1;
        end else begin
            case (m_state)
                3'd1: if (a0) begin
                    s[1] = 1'b1; m_vec = d[7:3];
                    m_state = !m_sngl ? 3'd2 : (m_ic4 ? 3'd3 : 3'd4);
                end
                3'd2: if (a0) begin
                    s[2] = 1'b1; m_cas = d; m_state = m_ic4 ? 3'd3 : 3'd4;
                end
                3'd3: if (a0) begin
                    s[3] = 1'b1; m_icw4 = d[4:0]; m_state = 3'd4;
                end
                3'd4: begin
                    if (a0)        s[4] = 1'b1;
                    else if (!d[3]) s[5] = 1'b1;
                    else           s[6] = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic push_exp(input logic [6:0] s);
        exp_t e;
        if (s != '0) begin
            e.cyc = cyc + 1;
            e.stb = s;
            e.st  = m_state;
            e.cfg = {m_sngl, m_ic4, m_vec, m_cas, m_icw4};
            sb_q.push_back(e);
        end
    endtask

    // One CPU write; bus is corrupted after the accept cycle to show only that cycle is sampled.
    task automatic wr(input bit a0, input logic [7:0] d, input int hold);
        logic [6:0] s;
        @(posedge clock); #1;
        address_0 = a0; internal_data_bus = d; write_enable = 1'b1;
        model_step(a0, d, s);
        push_exp(s);
        @(posedge clock); #1;
        address_0 = ~a0; internal_data_bus = ~d;
        for (int i = 1; i < hold; i++) begin
            @(posedge clock); #1;
        end
        write_enable = 1'b0;
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin
        if (stb != '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {25'd0, stb}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("strobe", {25'd0, stb}, {25'd0, mon_e.stb});
                chk("strobe_cycle", cyc, mon_e.cyc);
                chk("state_at_strobe", {29'd0, initialization_state}, {29'd0, mon_e.st});
                chk("config_at_strobe", {11'd0, cfg}, {11'd0, mon_e.cfg});
            end
        end
    end

    initial begin
        logic [6:0] s;
        reset_n = 1'b0; write_enable = 1'b0; address_0 = 1'b0; internal_data_bus = '0;
        m_reset();
        #12;
        chk("rst_state", {29'd0, initialization_state}, 32'd0);
        chk("rst_strobes", {25'd0, stb}, 32'd0);
        chk("rst_config", {11'd0, cfg}, 32'd0);
        chk("rst_complete", {31'd0, initialization_complete}, 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;

        // IDLE with OCW lock: none of these may strobe
        wr(1'b1, 8'hFF, 1); wr(1'b0, 8'h20, 1); wr(1'b0, 8'h0B, 1);
        chk("idle_state", {29'd0, initialization_state}, 32'd0);

        // single, no ICW4
        wr(1'b0, 8'h12, 1);
        chk("s1_state", {29'd0, initialization_state}, 32'd1);
        wr(1'b1, 8'h40, 1);
        chk("s1_vector", {27'd0, interrupt_vector_base}, 32'h08);
        chk("s1_state_ready", {29'd0, initialization_state}, 32'd4);
        chk("s1_complete", {31'd0, initialization_complete}, 32'd1);

        // READY: OCW1, OCW2, OCW3
        wr(1'b1, 8'hFF, 1); wr(1'b0, 8'h20, 1); wr(1'b0, 8'h0B, 1);
        chk("ocw_state", {29'd0, initialization_state}, 32'd4);

        // cascade with ICW3 and ICW4
        wr(1'b0, 8'h11, 1);
        chk("s2_state1", {29'd0, initialization_state}, 32'd1);
        wr(1'b0, 8'h20, 1);
        chk("s2_ignored", {29'd0, initialization_state}, 32'd1);
        wr(1'b1, 8'h08, 1);
        chk("s2_state2", {29'd0, initialization_state}, 32'd2);
        wr(1'b1, 8'h04, 1);
        chk("s2_state3", {29'd0, initialization_state}, 32'd3);
        wr(1'b1, 8'h1D, 1);
        chk("s2_state4", {29'd0, initialization_state}, 32'd4);
        chk("s2_cascade", {24'd0, cascade_config}, 32'h04);
        chk("s2_icw4", {27'd0, icw4_config}, 32'h1D);

        // restart from WAIT_ICW3
        wr(1'b0, 8'h11, 1); wr(1'b1, 8'h10, 1);
        chk("rs_state2", {29'd0, initialization_state}, 32'd2);
        wr(1'b0, 8'h13, 1);
        chk("rs_state1", {29'd0, initialization_state}, 32'd1);
        chk("rs_icw4_clr", {27'd0, icw4_config}, 32'd0);
        chk("rs_cascade_kept", {24'd0, cascade_config}, 32'h04);
        chk("rs_vector_kept", {27'd0, interrupt_vector_base}, 32'h02);
        wr(1'b1, 8'hF8, 1);
        chk("rs_state3", {29'd0, initialization_state}, 32'd3);
        wr(1'b1, 8'h03, 1);
        chk("rs_icw4", {27'd0, icw4_config}, 32'h03);

        // long write_enable hold: one ICW1 only
        wr(1'b0, 8'h13, 5);
        chk("hold_state", {29'd0, initialization_state}, 32'd1);

        // async reset in WAIT_ICW4 with a write arriving
        wr(1'b1, 8'h20, 1);
        chk("pre_rst_state", {29'd0, initialization_state}, 32'd3);
        @(posedge clock); #1;
        address_0 = 1'b0; internal_data_bus = 8'h13; write_enable = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_state", {29'd0, initialization_state}, 32'd0);
        chk("arst_outputs", {8'd0, stb, initialization_complete, cfg, initialization_state}, 32'd0);
        m_reset();
        @(posedge clock); #1;
        reset_n = 1'b1;
        model_step(1'b0, 8'h13, s);
        push_exp(s);
        @(posedge clock); #1 write_enable = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_state", {29'd0, initialization_state}, 32'd1);

        repeat (3) @(posedge clock);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
